rvm_mem_ctrl: RTL

Memory port controller for the multi-cycle core. Arbitrates the single external memory bus between the instruction-fetch requester and the load/store requester. Sequences each transaction through a small state machine, generates word-aligned addresses and byte enables, and returns sign- or zero-extended read data. Sits between the core control path and the top-level `mem_*` pins.

---
 rtl/rvm_mem_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/rvm_mem_ctrl.sv
// Memory port controller: arbitrates instruction fetch and load/store onto one external bus.
// Define RVM_MEM_CTRL_TIMEOUT_EN to compile in the stalled-bus timeout.
module rvm_mem_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_done,
   output logic [31:0] f_rdata,
   output logic        f_error,
   input  logic        d_req,
   input  logic        d_wen,
   input  logic [1:0]  d_size,
   input  logic        d_signed,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        d_error,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_c_en,
   output logic        mem_w_en,
   output logic [3:0]  mem_b_en,
   input  logic [31:0] mem_rdata,
   input  logic        mem_error,
   input  logic        mem_stall
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("rvm_mem_ctrl: TIMEOUT_CYCLES must be in 1..255");
   end

   state_t      state, next_state;
   logic        take_d, take_f, misaligned, timeout, done_now, fail;
   logic [3:0]  be_new;
   logic [29:0] word_addr;
   logic [31:0] wdata_new, load_ext;
   logic [15:0] lane_data;
   logic        unused_fetch_offset;

   logic        is_data, lat_signed;
   logic [1:0]  lat_size, lat_off;

   logic        c_en_nx, w_en_nx, f_done_nx, d_done_nx, f_error_nx, d_error_nx;
   logic [3:0]  b_en_nx;
   logic [31:0] addr_nx, wdata_nx, f_rdata_nx, d_rdata_nx;

   // Fetches are always full words, so the fetch byte offset is deliberately dropped.
   assign unused_fetch_offset = ^f_addr[1:0];

   always_comb begin
      take_d    = (state == S_IDLE) && d_req;
      take_f    = (state == S_IDLE) && f_req && !d_req;
      word_addr = d_req ? d_addr[31:2] : f_addr[31:2];
      case (d_size)
         2'b00: begin
            misaligned = 1'b0;
            be_new     = 4'b0001 << d_addr[1:0];
            wdata_new  = {4{d_wdata[7:0]}};
         end
         2'b01: begin
            misaligned = d_addr[0];
            be_new     = d_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new  = {2{d_wdata[15:0]}};
         end
         2'b10: begin
            misaligned = |d_addr[1:0];
            be_new     = 4'b1111;
            wdata_new  = d_wdata;
         end
         default: begin
            misaligned = 1'b1;
            be_new     = 4'b1111;
            wdata_new  = d_wdata;
         end
      endcase
      if (!d_req) be_new = 4'b1111;
   end

`ifdef RVM_MEM_CTRL_TIMEOUT_EN
   logic [7:0] stall_cnt;

   // Held at zero outside BUSY, which is the same as clearing it on entry.
   always_ff @(posedge clk) begin
      if (reset || state != S_BUSY) stall_cnt <= '0;
      else if (mem_stall)           stall_cnt <= stall_cnt + 8'd1;
   end

   assign timeout = (state == S_BUSY) && mem_stall && (stall_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   assign done_now = (state == S_BUSY) && (!mem_stall || timeout);
   // A completion taken while still stalled can only be the timeout.
   assign fail     = mem_stall || mem_error;

   always_comb begin
      lane_data = 16'(mem_rdata >> {lat_off, 3'b000});
      case (lat_size)
         2'b00:   load_ext = {{24{lat_signed & lane_data[7]}}, lane_data[7:0]};
         2'b01:   load_ext = {{16{lat_signed & lane_data[15]}}, lane_data[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (take_d)      next_state = misaligned ? S_RESP : S_BUSY;
                  else if (take_f) next_state = S_BUSY;
         S_BUSY:  if (done_now)    next_state = S_RESP;
         S_RESP:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      c_en_nx    = 1'b0;
      w_en_nx    = 1'b0;
      b_en_nx    = 4'b0000;
      addr_nx    = mem_addr;
      wdata_nx   = mem_wdata;
      f_done_nx  = 1'b0;
      d_done_nx  = 1'b0;
      f_error_nx = 1'b0;
      d_error_nx = 1'b0;
      f_rdata_nx = '0;
      d_rdata_nx = '0;
      case (state)
         S_IDLE: begin
            if (next_state == S_BUSY) begin
               c_en_nx  = 1'b1;
               w_en_nx  = take_d && d_wen;
               b_en_nx  = be_new;
               addr_nx  = {word_addr, 2'b00};
               wdata_nx = wdata_new;
            end else if (take_d) begin
               d_done_nx  = 1'b1;
               d_error_nx = 1'b1;
            end
         end
         S_BUSY: begin
            if (done_now) begin
               if (is_data) begin
                  d_done_nx  = 1'b1;
                  d_error_nx = fail;
                  d_rdata_nx = fail ? '0 : load_ext;
               end else begin
                  f_done_nx  = 1'b1;
                  f_error_nx = fail;
                  f_rdata_nx = fail ? '0 : mem_rdata;
               end
            end else begin
               c_en_nx = 1'b1;
               w_en_nx = mem_w_en;
               b_en_nx = mem_b_en;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         is_data    <= 1'b0;
         lat_signed <= 1'b0;
         lat_size   <= 2'b00;
         lat_off    <= 2'b00;
      end else if (take_d || take_f) begin
         is_data    <= take_d;
         lat_signed <= d_signed;
         lat_size   <= d_size;
         lat_off    <= d_addr[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_c_en  <= 1'b0;
         mem_w_en  <= 1'b0;
         mem_b_en  <= 4'b0000;
         mem_addr  <= '0;
         mem_wdata <= '0;
         f_done    <= 1'b0;
         d_done    <= 1'b0;
         f_error   <= 1'b0;
         d_error   <= 1'b0;
         f_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         mem_c_en  <= c_en_nx;
         mem_w_en  <= w_en_nx;
         mem_b_en  <= b_en_nx;
         mem_addr  <= addr_nx;
         mem_wdata <= wdata_nx;
         f_done    <= f_done_nx;
         d_done    <= d_done_nx;
         f_error   <= f_error_nx;
         d_error   <= d_error_nx;
         f_rdata   <= f_rdata_nx;
         d_rdata   <= d_rdata_nx;
      end
   end

endmodule
